// File: rtl/mac_dot_product_ctrl.sv
// rtl/mac_dot_product_ctrl.sv - dot-product sequencer driving a shared MAC unit
//
// Runs one dot product per command: clears the MAC accumulator, streams
// length operand pairs from two synchronous-read memories into the MAC,
// then latches the final accumulator value.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start, abort        job request / job cancel
//   length, base_a/b    job size (0..2^ADDR_WIDTH) and vector start addresses
//   mem_rd_en, mem_addr_a/b, mem_data_a/b
//                       operand memory read port (data one cycle after strobe)
//   mac_multiplier, mac_multiplicand, mac_valid, mac_clear, mac_result
//                       MAC unit interface
//   busy, done, dot_result
//                       job status and latched result
module mac_dot_product_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic [ADDR_WIDTH-1:0] base_a,
    input  logic [ADDR_WIDTH-1:0] base_b,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr_a,
    output logic [ADDR_WIDTH-1:0] mem_addr_b,
    input  logic [DATA_WIDTH-1:0] mem_data_a,
    input  logic [DATA_WIDTH-1:0] mem_data_b,
    output logic [DATA_WIDTH-1:0] mac_multiplier,
    output logic [DATA_WIDTH-1:0] mac_multiplicand,
    output logic                  mac_valid,
    output logic                  mac_clear,
    input  logic [ACC_WIDTH-1:0]  mac_result,
    output logic                  busy,
    output logic                  done,
    output logic [ACC_WIDTH-1:0]  dot_result
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH+1)'(1);

    state_t                state;
    state_t                next_state;

    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH-1:0] base_a_q;
    logic [ADDR_WIDTH-1:0] base_b_q;
    logic [ADDR_WIDTH:0]   issue_idx;
    logic [ADDR_WIDTH:0]   beat_cnt;
    logic                  valid_q;
    logic [ACC_WIDTH-1:0]  dot_result_q;

    logic                  rd_en;
    logic                  clear;
    logic                  capture;
    logic                  latch;
    logic                  job_active;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        rd_en      = 1'b0;
        clear      = 1'b0;
        capture    = 1'b0;
        latch      = 1'b0;
        job_active = (state == CLEAR) || (state == RUN) || (state == DRAIN);

        case (state)
            IDLE: begin
                if (start) begin
                    capture    = 1'b1;
                    next_state = CLEAR;
                end
            end
            CLEAR: begin
                clear      = 1'b1;
                rd_en      = (len_q != '0);
                next_state = (len_q != '0) ? RUN : DRAIN;
            end
            RUN: begin
                rd_en = (issue_idx < len_q);
                // The beat being presented now is the last one of the job.
                if (valid_q && (beat_cnt == len_q - ONE)) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                latch      = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                if (start) begin
                    capture    = 1'b1;
                    next_state = CLEAR;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase

        // Abort wins over everything while a job is running and suppresses
        // the result latch, so dot_result keeps the previous job's value.
        if (abort && job_active) begin
            next_state = IDLE;
            latch      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q        <= '0;
            base_a_q     <= '0;
            base_b_q     <= '0;
            issue_idx    <= '0;
            beat_cnt     <= '0;
            valid_q      <= 1'b0;
            dot_result_q <= '0;
        end else begin
            // Read data arrives one cycle after the strobe, so the MAC valid
            // is the strobe delayed by one; an abort drops the in-flight beat.
            valid_q <= rd_en && !(abort && job_active);

            if (capture) begin
                len_q     <= (length > MAX_LEN) ? MAX_LEN : length;
                base_a_q  <= base_a;
                base_b_q  <= base_b;
                issue_idx <= '0;
                beat_cnt  <= '0;
            end else begin
                if (rd_en) begin
                    issue_idx <= issue_idx + ONE;
                end
                if (valid_q) begin
                    beat_cnt <= beat_cnt + ONE;
                end
            end

            if (latch) begin
                dot_result_q <= mac_result;
            end
        end
    end

    // Addresses wrap naturally modulo 2^ADDR_WIDTH; held at 0 when idle.
    assign mem_rd_en        = rd_en;
    assign mem_addr_a       = rd_en ? (base_a_q + issue_idx[ADDR_WIDTH-1:0]) : '0;
    assign mem_addr_b       = rd_en ? (base_b_q + issue_idx[ADDR_WIDTH-1:0]) : '0;
    assign mac_multiplier   = mem_data_a;
    assign mac_multiplicand = mem_data_b;
    assign mac_valid        = valid_q;
    assign mac_clear        = clear;
    assign busy             = job_active;
    assign done             = (state == DONE);
    assign dot_result       = dot_result_q;

endmodule

// File: tb/tb_mac_dot_product_ctrl.sv
// tb/tb_mac_dot_product_ctrl.sv - directed self-checking bench for mac_dot_product_ctrl
module tb_mac_dot_product_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [8:0]  length;
    logic [7:0]  base_a;
    logic [7:0]  base_b;
    logic        mem_rd_en;
    logic [7:0]  mem_addr_a;
    logic [7:0]  mem_addr_b;
    logic [15:0] mem_data_a;
    logic [15:0] mem_data_b;
    logic [15:0] mac_multiplier;
    logic [15:0] mac_multiplicand;
    logic        mac_valid;
    logic        mac_clear;
    logic [31:0] mac_result;
    logic        busy;
    logic        done;
    logic [31:0] dot_result;

    logic [15:0] mem_a [256];
    logic [15:0] mem_b [256];
    logic [31:0] acc;
    int          addr_log[$];

    int n_vec    = 0;
    int n_miscmp = 0;

    always #5 clk = ~clk;

    mac_dot_product_ctrl #(
        .DATA_WIDTH(16),
        .ACC_WIDTH (32),
        .ADDR_WIDTH(8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .abort           (abort),
        .length          (length),
        .base_a          (base_a),
        .base_b          (base_b),
        .mem_rd_en       (mem_rd_en),
        .mem_addr_a      (mem_addr_a),
        .mem_addr_b      (mem_addr_b),
        .mem_data_a      (mem_data_a),
        .mem_data_b      (mem_data_b),
        .mac_multiplier  (mac_multiplier),
        .mac_multiplicand(mac_multiplicand),
        .mac_valid       (mac_valid),
        .mac_clear       (mac_clear),
        .mac_result      (mac_result),
        .busy            (busy),
        .done            (done),
        .dot_result      (dot_result)
    );

    always_ff @(posedge clk) begin
        if (mem_rd_en) begin
            mem_data_a <= mem_a[mem_addr_a];
            mem_data_b <= mem_b[mem_addr_b];
        end
    end

    always_ff @(posedge clk) begin
        if (reset || mac_clear) begin
            acc <= '0;
        end else if (mac_valid) begin
            acc <= acc + ({{16{mac_multiplier[15]}}, mac_multiplier} *
                          {{16{mac_multiplicand[15]}}, mac_multiplicand});
        end
    end
    assign mac_result = acc;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Called at a negedge; start is sampled on the following posedge and the
    // task returns at the negedge of cycle +1.
    task automatic launch(input int len, input int ba, input int bb);
        start  = 1'b1;
        length = 9'(len);
        base_a = 8'(ba);
        base_b = 8'(bb);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Starts at cycle +1 and returns at the negedge of the done cycle.
    task automatic observe(input string tag, input int len, input logic [31:0] exp_res);
        int clr_cyc, first_v, last_v, v_cnt, rd_cnt, ovl, done_cyc;
        clr_cyc  = -1;
        first_v  = -1;
        last_v   = -1;
        v_cnt    = 0;
        rd_cnt   = 0;
        ovl      = 0;
        done_cyc = -1;
        addr_log.delete();
        for (int k = 1; k <= len + 10; k++) begin
            if (mac_clear && clr_cyc < 0) clr_cyc = k;
            if (mac_valid) begin
                if (first_v < 0) first_v = k;
                last_v = k;
                v_cnt++;
            end
            if (mem_rd_en) begin
                rd_cnt++;
                addr_log.push_back(int'(mem_addr_a));
            end
            if (mac_clear && mac_valid) ovl++;
            if (done) begin
                done_cyc = k;
                break;
            end
            @(negedge clk);
        end
        check_eq({tag, ".clear_cycle"}, 64'(clr_cyc), 64'(1));
        check_eq({tag, ".valid_beats"}, 64'(v_cnt), 64'(len));
        check_eq({tag, ".reads"}, 64'(rd_cnt), 64'(len));
        check_eq({tag, ".clear_valid_overlap"}, 64'(ovl), 64'(0));
        if (len > 0) begin
            check_eq({tag, ".first_valid"}, 64'(first_v), 64'(2));
            check_eq({tag, ".last_valid"}, 64'(last_v), 64'(len + 1));
        end
        check_eq({tag, ".done_cycle"}, 64'(done_cyc), 64'(len + 3));
        check_eq({tag, ".dot_result"}, 64'(dot_result), 64'(exp_res));
    endtask

    initial begin
        int dn;
        reset  = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        length = '0;
        base_a = '0;
        base_b = '0;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        repeat (3) @(negedge clk);
        check_eq("rst.busy", 64'(busy), 64'(0));
        check_eq("rst.done", 64'(done), 64'(0));
        check_eq("rst.rd_en", 64'(mem_rd_en), 64'(0));
        check_eq("rst.mac_valid", 64'(mac_valid), 64'(0));
        check_eq("rst.mac_clear", 64'(mac_clear), 64'(0));
        check_eq("rst.dot_result", 64'(dot_result), 64'(0));
        check_eq("rst.addr_a", 64'(mem_addr_a), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        // Basic job: 200 - 375 - 40 = -215
        mem_a[0] = 16'd10;  mem_a[1] = -16'sd15; mem_a[2] = 16'd5;
        mem_b[0] = 16'd20;  mem_b[1] = 16'd25;   mem_b[2] = -16'sd8;
        mem_a[10] = -16'sd30;
        mem_b[10] = -16'sd2;
        launch(3, 0, 0);
        observe("basic", 3, -32'sd215);

        // Back-to-back: start held in DONE
        launch(1, 10, 10);
        observe("b2b", 1, 32'd60);
        @(negedge clk);

        // Empty job
        launch(0, 5, 5);
        observe("len0", 0, 32'd0);
        @(negedge clk);

        // Address wrap: 21 - 32 - 45 + 60 = 4
        mem_a[254] = 16'd3; mem_a[255] = -16'sd4; mem_a[0] = 16'd5;   mem_a[1] = 16'd6;
        mem_b[0]   = 16'd7; mem_b[1]   = 16'd8;   mem_b[2] = -16'sd9; mem_b[3] = 16'd10;
        launch(4, 254, 0);
        observe("wrap", 4, 32'd4);
        check_eq("wrap.addr_cnt", 64'(addr_log.size()), 64'(4));
        if (addr_log.size() == 4) begin
            check_eq("wrap.addr0", 64'(addr_log[0]), 64'(254));
            check_eq("wrap.addr1", 64'(addr_log[1]), 64'(255));
            check_eq("wrap.addr2", 64'(addr_log[2]), 64'(0));
            check_eq("wrap.addr3", 64'(addr_log[3]), 64'(1));
        end
        @(negedge clk);

        // Accumulator wrap: 3 * 2^30
        for (int i = 20; i < 23; i++) begin
            mem_a[i] = 16'h8000;
            mem_b[i] = 16'h8000;
        end
        launch(3, 20, 20);
        observe("ovf", 3, 32'hC000_0000);
        @(negedge clk);

        // Abort during RUN, then a fresh job
        for (int i = 40; i < 48; i++) begin
            mem_a[i] = 16'd1;
            mem_b[i] = 16'd1;
        end
        launch(8, 40, 40);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check_eq("abort.busy", 64'(busy), 64'(0));
        check_eq("abort.rd_en", 64'(mem_rd_en), 64'(0));
        check_eq("abort.mac_valid", 64'(mac_valid), 64'(0));
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) dn++;
            @(negedge clk);
        end
        check_eq("abort.no_done", 64'(dn), 64'(0));
        check_eq("abort.dot_kept", 64'(dot_result), 64'(32'hC000_0000));
        mem_a[50] = 16'd7;
        mem_b[50] = 16'd6;
        launch(1, 50, 50);
        observe("post_abort", 1, 32'd42);
        @(negedge clk);

        // Oversized length saturates to 256
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 16'd1;
            mem_b[i] = 16'd1;
        end
        launch(511, 0, 0);
        observe("sat", 256, 32'd256);
        @(negedge clk);

        // Reset mid-job
        launch(5, 0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("midrst.busy", 64'(busy), 64'(0));
        check_eq("midrst.rd_en", 64'(mem_rd_en), 64'(0));
        check_eq("midrst.mac_valid", 64'(mac_valid), 64'(0));
        check_eq("midrst.done", 64'(done), 64'(0));
        check_eq("midrst.dot_result", 64'(dot_result), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
